// File: rtl/hack_pc_if.sv
// Fetch-side bus of the Hack program counter: control requests in,
// fetch address and status flags out. The master is the instruction
// sequencer/bench; the slave is hack_pc.
interface hack_pc_if #(
  parameter int ADDR_WIDTH = 15
) ();
  logic                  inc;
  logic                  load;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic                  call;
  logic                  ret;
  logic                  fetch_ready;
  logic                  fetch_valid;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic                  halted;
  logic                  wrap;
  logic                  stack_err;

  modport master (
    output inc, load, load_addr, call, ret, fetch_ready,
    input  fetch_valid, pc_out, halted, wrap, stack_err
  );

  modport slave (
    input  inc, load, load_addr, call, ret, fetch_ready,
    output fetch_valid, pc_out, halted, wrap, stack_err
  );
endinterface

// File: rtl/hack_pc.sv
// Hack CPU program counter with BOOT/RUN/HALT sequencing.
// Optional return-address stack enabled by macro HACK_PC_STACK_EN; without
// it, call/ret are ignored and stack_err is tied low.
//
// state | meaning
// BOOT  | one cycle after reset release, no fetch issued
// RUN   | fetch_valid high, PC advances on each accepted fetch
// HALT  | self-jump detected, fetch stopped until reset
module hack_pc #(
  parameter int ADDR_WIDTH   = 15,
  parameter int RESET_VECTOR = 0,
  parameter int STACK_DEPTH  = 4
) (
  input logic      clk,
  input logic      rst_n,
  hack_pc_if.slave bus
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [ADDR_WIDTH-1:0] RV = ADDR_WIDTH'(RESET_VECTOR);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt, pc_inc;
  logic                  inc_carry;
  logic                  wrap_q, wrap_set;
  logic                  accept;

  assign accept          = (state == RUN) && bus.fetch_ready;
  assign bus.fetch_valid = (state == RUN);
  assign bus.halted      = (state == HALT);
  assign bus.pc_out      = pc;
  assign bus.wrap        = wrap_q;

`ifdef HACK_PC_STACK_EN
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]       sp, sp_m1;
  logic                  full, empty, push, pop, err_q, err_set;

  assign sp_m1         = sp - SP_W'(1);
  assign full          = (sp == SP_W'(STACK_DEPTH));
  assign empty         = (sp == '0);
  assign bus.stack_err = err_q;

  // Return-address LIFO; entries need no reset since sp marks validity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp    <= '0;
      err_q <= 1'b0;
    end else begin
      if (err_set) err_q <= 1'b1;
      if (push) begin
        stack_mem[sp[SP_W-2:0]] <= pc_inc;
        sp <= sp + SP_W'(1);
      end else if (pop) begin
        sp <= sp_m1;
      end
    end
  end
`else
  logic unused_req;
  assign unused_req    = bus.call ^ bus.ret;
  assign bus.stack_err = 1'b0;
`endif

  // Ripple incrementer: carry chain from LSB, carry-out flags the wrap.
  always_comb begin
    logic carry;
    carry = 1'b1;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      pc_inc[i] = pc[i] ^ carry;
      carry     = pc[i] & carry;
    end
    inc_carry = carry;
  end

  // Next-state and next-PC selection; priority call > ret > load > inc.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    wrap_set  = 1'b0;
`ifdef HACK_PC_STACK_EN
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
`endif
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (accept) begin
`ifdef HACK_PC_STACK_EN
          if (bus.call) begin
            pc_nxt = bus.load_addr;
            if (full) err_set = 1'b1;
            else      push    = 1'b1;
          end else if (bus.ret) begin
            if (empty) begin
              err_set  = 1'b1;
              pc_nxt   = pc_inc;
              wrap_set = inc_carry;
            end else begin
              pop    = 1'b1;
              pc_nxt = stack_mem[sp_m1[SP_W-2:0]];
            end
          end else
`endif
          if (bus.load) begin
            pc_nxt = bus.load_addr;
            if (bus.load_addr == pc) state_nxt = HALT;
          end else if (bus.inc) begin
            pc_nxt   = pc_inc;
            wrap_set = inc_carry;
          end
        end
      end
      default: state_nxt = HALT;
    endcase
  end

  // State, PC and sticky wrap registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= BOOT;
      pc     <= RV;
      wrap_q <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (wrap_set) wrap_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hack_pc.sv
// Directed testbench for hack_pc; stack scenarios follow HACK_PC_STACK_EN.
module tb_hack_pc;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  hack_pc_if #(.ADDR_WIDTH(AW)) bus ();

  hack_pc #(.ADDR_WIDTH(AW), .RESET_VECTOR(0), .STACK_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.inc = 0; bus.load = 0; bus.call = 0; bus.ret = 0;
    bus.load_addr = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
    bus.fetch_ready = 1;
    step();
  endtask

  task automatic test_reset();
    idle();
    bus.fetch_ready = 1;
    bus.inc = 1;
    rst_n = 0;
    step();
    n_cmp++; if (bus.fetch_valid !== 1'b0) begin n_bad++; $display("FAIL reset_fv got %b want 0", bus.fetch_valid); end
    n_cmp++; if (bus.pc_out !== 15'h0) begin n_bad++; $display("FAIL reset_pc got %h want 0", bus.pc_out); end
    n_cmp++; if ({bus.halted, bus.wrap, bus.stack_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {bus.halted, bus.wrap, bus.stack_err}); end
    rst_n = 1;
    step();
    n_cmp++; if (bus.fetch_valid !== 1'b1 || bus.pc_out !== 15'h0) begin n_bad++; $display("FAIL boot_exit got fv=%b pc=%h want fv=1 pc=0", bus.fetch_valid, bus.pc_out); end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++; if (bus.pc_out !== AW'(i)) begin n_bad++; $display("FAIL inc_seq got %h want %h", bus.pc_out, AW'(i)); end
    end
  endtask

  task automatic test_hold();
    idle(); bus.load = 1; bus.load_addr = 15'h5;
    step();
    idle(); bus.inc = 1; bus.fetch_ready = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (bus.pc_out !== 15'h5) begin n_bad++; $display("FAIL hold got %h want 5", bus.pc_out); end
    end
    bus.fetch_ready = 1;
    step();
    n_cmp++; if (bus.pc_out !== 15'h6) begin n_bad++; $display("FAIL hold_release got %h want 6", bus.pc_out); end
  endtask

  task automatic test_priority();
    idle(); bus.load = 1; bus.inc = 1; bus.load_addr = 15'h100;
    step();
    n_cmp++; if (bus.pc_out !== 15'h100) begin n_bad++; $display("FAIL load_over_inc got %h want 100", bus.pc_out); end
    idle(); bus.call = 1; bus.inc = 1; bus.load_addr = 15'h200;
    step();
`ifdef HACK_PC_STACK_EN
    n_cmp++; if (bus.pc_out !== 15'h200) begin n_bad++; $display("FAIL call_over_inc got %h want 200", bus.pc_out); end
`else
    n_cmp++; if (bus.pc_out !== 15'h101) begin n_bad++; $display("FAIL call_ignored got %h want 101", bus.pc_out); end
    idle(); bus.ret = 1;
    step();
    n_cmp++; if (bus.pc_out !== 15'h101 || bus.stack_err !== 1'b0) begin n_bad++; $display("FAIL ret_ignored got pc=%h err=%b want pc=101 err=0", bus.pc_out, bus.stack_err); end
`endif
  endtask

  task automatic test_wrap();
    idle(); bus.load = 1; bus.load_addr = 15'h7FFF;
    step();
    n_cmp++; if (bus.pc_out !== 15'h7FFF || bus.wrap !== 1'b0) begin n_bad++; $display("FAIL wrap_pre got pc=%h wrap=%b want 7fff 0", bus.pc_out, bus.wrap); end
    idle(); bus.inc = 1;
    step();
    n_cmp++; if (bus.pc_out !== 15'h0 || bus.wrap !== 1'b1) begin n_bad++; $display("FAIL wrap got pc=%h wrap=%b want 0 1", bus.pc_out, bus.wrap); end
    step();
    n_cmp++; if (bus.pc_out !== 15'h1 || bus.wrap !== 1'b1) begin n_bad++; $display("FAIL wrap_sticky got pc=%h wrap=%b want 1 1", bus.pc_out, bus.wrap); end
  endtask

  task automatic test_halt();
    idle(); bus.load = 1; bus.load_addr = 15'h12;
    step();
    n_cmp++; if (bus.halted !== 1'b0 || bus.pc_out !== 15'h12) begin n_bad++; $display("FAIL pre_halt got h=%b pc=%h want 0 12", bus.halted, bus.pc_out); end
    step();
    n_cmp++; if (bus.halted !== 1'b1 || bus.fetch_valid !== 1'b0 || bus.pc_out !== 15'h12) begin n_bad++; $display("FAIL halt got h=%b fv=%b pc=%h want 1 0 12", bus.halted, bus.fetch_valid, bus.pc_out); end
    idle(); bus.load = 1; bus.load_addr = 15'h30;
    step();
    n_cmp++; if (bus.halted !== 1'b1 || bus.pc_out !== 15'h12) begin n_bad++; $display("FAIL halt_stuck got h=%b pc=%h want 1 12", bus.halted, bus.pc_out); end
    idle(); bus.inc = 1; rst_n = 0;
    step();
    n_cmp++; if (bus.halted !== 1'b0 || bus.pc_out !== 15'h0 || bus.wrap !== 1'b0 || bus.fetch_valid !== 1'b0) begin n_bad++; $display("FAIL halt_reset got h=%b pc=%h w=%b fv=%b want 0 0 0 0", bus.halted, bus.pc_out, bus.wrap, bus.fetch_valid); end
    rst_n = 1; idle();
    step();
    n_cmp++; if (bus.fetch_valid !== 1'b1) begin n_bad++; $display("FAIL halt_reboot got fv=%b want 1", bus.fetch_valid); end
  endtask

`ifdef HACK_PC_STACK_EN
  task automatic test_stack();
    logic [AW-1:0] exp_ret [4];
    exp_ret = '{15'h51, 15'h51, 15'h51, 15'h12};
    do_reset();
    idle(); bus.load = 1; bus.load_addr = 15'h10;
    step();
    idle(); bus.call = 1; bus.load_addr = 15'h40;
    step();
    n_cmp++; if (bus.pc_out !== 15'h40) begin n_bad++; $display("FAIL call got %h want 40", bus.pc_out); end
    step();
    n_cmp++; if (bus.pc_out !== 15'h40 || bus.halted !== 1'b0) begin n_bad++; $display("FAIL call_self_no_halt got pc=%h h=%b want 40 0", bus.pc_out, bus.halted); end
    idle(); bus.ret = 1;
    step();
    n_cmp++; if (bus.pc_out !== 15'h41) begin n_bad++; $display("FAIL ret_inner got %h want 41", bus.pc_out); end
    step();
    n_cmp++; if (bus.pc_out !== 15'h11) begin n_bad++; $display("FAIL ret got %h want 11", bus.pc_out); end
    idle(); bus.call = 1; bus.load_addr = 15'h50;
    for (int i = 1; i <= 5; i++) begin
      step();
      n_cmp++; if (bus.stack_err !== (i == 5) || bus.pc_out !== 15'h50) begin n_bad++; $display("FAIL call_fill_%0d got err=%b pc=%h want err=%b pc=50", i, bus.stack_err, bus.pc_out, (i == 5)); end
    end
    idle(); bus.ret = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (bus.pc_out !== exp_ret[i]) begin n_bad++; $display("FAIL ret_unwind_%0d got %h want %h", i, bus.pc_out, exp_ret[i]); end
    end
    do_reset();
    idle(); bus.ret = 1;
    step();
    n_cmp++; if (bus.stack_err !== 1'b1 || bus.pc_out !== 15'h1) begin n_bad++; $display("FAIL underflow got err=%b pc=%h want 1 1", bus.stack_err, bus.pc_out); end
  endtask
`endif

  initial begin
    rst_n = 0;
    bus.fetch_ready = 0;
    idle();
    test_reset();
    test_hold();
    test_priority();
    test_wrap();
    test_halt();
`ifdef HACK_PC_STACK_EN
    test_stack();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
